// File: rtl/uart_rx_apb_fifo_if.sv
// APB3 slave bus bundle for the UART receiver with receive FIFO.
interface uart_rx_apb_fifo_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [3:0]  PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/uart_rx_apb_fifo.sv
// UART receiver with 2-flop input synchroniser, receive FIFO, sticky error
// flags, level interrupt and a zero-wait APB3 read-out port.
// Optional feature macro: UART_RX_PARITY_EN inserts a parity bit after the
// data bits (PARITY_ODD selects odd/even); without it STATUS[4] reads 0.
module uart_rx_apb_fifo #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   uart_rx_apb_fifo_if.slave  apb,
   input  logic               rx_serial,
   output logic               rx_done,
   output logic               irq
);

   localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;

   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd4;
`endif

   // Reject parameter sets the datapath is not built for
   if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 8 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_param_check
      $error("uart_rx_apb_fifo: illegal parameter set");
   end

   // Synchroniser and edge-detect history
   logic rx_meta_q, rx_s_q, rx_prev_q;

   // Receiver FSM state
   logic [2:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_bad_q, par_bad_d;
   logic                 push_req_c, frame_set_c, par_set_c;

   // FIFO and flags
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]     count_q, count_d;
   logic                 overrun_q, frame_err_q, parity_err_q;
   logic                 overrun_d, frame_err_d, parity_err_d;
   logic                 empty_c, full_c, push_c, pop_c, ovr_set_c;

   // APB decode
   logic                 access_c, rd_c, wr_c;
   logic [2:0]           w1c_c;
   logic [31:0]          status_c;
   logic                 unused_bits;

   assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA[31:5], apb.PWDATA[1:0]};

   // Two-flop synchroniser plus one history flop for falling-edge detection
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_serial;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
      end
   end

   // Receiver FSM state register
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         par_bad_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         par_bad_q <= par_bad_d;
      end
   end

   // Receiver FSM next state: bit timing, sampling and frame verdict
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      par_bad_d   = par_bad_q;
      push_req_c  = 1'b0;
      frame_set_c = 1'b0;
      par_set_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d     = '0;
            bit_d     = '0;
            par_bad_d = 1'b0;
            // Only a fresh 1->0 transition starts a frame; a held-low line does not
            if (rx_prev_q && !rx_s_q) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_CNT) begin
               cnt_d   = '0;
               state_d = rx_s_q ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
               bit_d   = bit_q + BIT_W'(1);
               if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d     = '0;
               par_bad_d = rx_s_q ^ (^shreg_q) ^ 1'(PARITY_ODD);
               state_d   = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (!rx_s_q)        frame_set_c = 1'b1;
               else if (par_bad_q) par_set_c   = 1'b1;
               else                push_req_c  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO control, flag update and APB decode
   always_comb begin
      access_c  = apb.PSEL && apb.PENABLE;
      rd_c      = access_c && !apb.PWRITE;
      wr_c      = access_c && apb.PWRITE;
      empty_c   = (count_q == '0);
      full_c    = (count_q == FULL_LVL);
      pop_c     = rd_c && (apb.PADDR[3:2] == 2'd0) && !empty_c;
      // A pop in the same cycle frees the slot a full FIFO needs
      push_c    = push_req_c && (!full_c || pop_c);
      ovr_set_c = push_req_c && full_c && !pop_c;
      w1c_c     = (wr_c && apb.PADDR[3:2] == 2'd1) ? apb.PWDATA[4:2] : 3'b000;

      count_d = count_q;
      case ({push_c, pop_c})
         2'b10:   count_d = count_q + LVL_W'(1);
         2'b01:   count_d = count_q - LVL_W'(1);
         default: count_d = count_q;
      endcase

      // Setting beats clearing when both land in the same cycle
      overrun_d    = ovr_set_c   || (overrun_q    && !w1c_c[0]);
      frame_err_d  = frame_set_c || (frame_err_q  && !w1c_c[1]);
      parity_err_d = par_set_c   || (parity_err_q && !w1c_c[2]);

      status_c = {16'd0, 8'(count_q), 3'd0, parity_err_q, frame_err_q,
                  overrun_q, full_c, empty_c};
   end

   // Read data and error response driven straight from the access phase
   always_comb begin
      apb.PRDATA  = '0;
      apb.PSLVERR = 1'b0;
      if (rd_c) begin
         case (apb.PADDR[3:2])
            2'd0: begin
               if (empty_c) apb.PSLVERR = 1'b1;
               else         apb.PRDATA  = 32'(mem_q[rd_ptr_q]);
            end
            2'd1:    apb.PRDATA = status_c;
            default: apb.PRDATA = '0;
         endcase
      end
   end

   assign apb.PREADY = 1'b1;

   // FIFO storage; contents need no reset since count gates every read
   always_ff @(posedge PCLK) begin
      if (push_c) mem_q[wr_ptr_q] <= shreg_q;
   end

   // FIFO pointers, level, sticky flags and registered outputs
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         rx_done      <= 1'b0;
         irq          <= 1'b0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q      <= count_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         rx_done      <= push_c;
         irq          <= (count_d != '0) || overrun_d || frame_err_d || parity_err_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_apb_fifo.sv
// Scoreboard bench for uart_rx_apb_fifo: a queue-based model of the FIFO and
// flags predicts every APB response and rx_done pulse; a monitor compares.
module tb_uart_rx_apb_fifo;

   localparam int unsigned CPB   = 16;
   localparam int unsigned DB    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PODD  = 0;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic rx_serial;
   logic rx_done;
   logic irq;

   uart_rx_apb_fifo_if apb();

   uart_rx_apb_fifo #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DB),
      .FIFO_DEPTH   (DEPTH),
      .PARITY_ODD   (PODD)
   ) dut (
      .PCLK      (clk),
      .PRESETn   (rst_n),
      .apb       (apb),
      .rx_serial (rx_serial),
      .rx_done   (rx_done),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_read;
      logic [31:0] data;
      logic        err;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   exp_done_q[$];
   int   mdl_q[$];
   bit   m_ovr, m_fe, m_pe;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_status();
      return {16'd0, 8'(mdl_q.size()), 3'd0, m_pe, m_fe, m_ovr,
              mdl_q.size() == DEPTH, mdl_q.size() == 0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apb_access(bit wr, logic [3:0] addr, logic [31:0] wdata);
      apb.PSEL    = 1'b1;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = wr;
      apb.PADDR   = addr;
      apb.PWDATA  = wdata;
      tick();
      apb.PENABLE = 1'b1;
      tick();
      apb.PSEL    = 1'b0;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = 1'b0;
   endtask

   task automatic apb_read(logic [3:0] addr, string name);
      exp_t e;
      e.is_read = 1'b1;
      e.err     = 1'b0;
      e.data    = '0;
      e.name    = name;
      case (addr[3:2])
         2'd0: begin
            if (mdl_q.size() == 0) e.err = 1'b1;
            else                   e.data = 32'(mdl_q.pop_front());
         end
         2'd1:    e.data = model_status();
         default: e.data = '0;
      endcase
      exp_q.push_back(e);
      apb_access(1'b0, addr, 32'd0);
   endtask

   task automatic apb_write(logic [3:0] addr, logic [31:0] wdata, string name);
      exp_t e;
      e.is_read = 1'b0;
      e.err     = 1'b0;
      e.data    = '0;
      e.name    = name;
      if (addr[3:2] == 2'd1) begin
         if (wdata[2]) m_ovr = 1'b0;
         if (wdata[3]) m_fe  = 1'b0;
         if (wdata[4]) m_pe  = 1'b0;
      end
      exp_q.push_back(e);
      apb_access(1'b1, addr, wdata);
   endtask

   task automatic send_frame(logic [7:0] data, bit stop_bit, bit par_flip);
      if (!stop_bit)                 m_fe = 1'b1;
      else if (PAR_EN && par_flip)   m_pe = 1'b1;
      else if (mdl_q.size() < DEPTH) begin
         mdl_q.push_back(int'(data));
         exp_done_q.push_back(int'(data));
      end else                       m_ovr = 1'b1;

      rx_serial = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < DB; i++) begin
         rx_serial = data[i];
         repeat (CPB) tick();
      end
      if (PAR_EN) begin
         rx_serial = (^data) ^ 1'(PODD) ^ par_flip;
         repeat (CPB) tick();
      end
      rx_serial = stop_bit;
      repeat (CPB) tick();
      rx_serial = 1'b1;
      if (!stop_bit) repeat (4) tick();
   endtask

   task automatic check_idle(string name);
      check({name, " irq"}, 32'(irq),
            32'((mdl_q.size() != 0) || m_ovr || m_fe || m_pe));
      check({name, " rx_done"}, 32'(rx_done), 32'd0);
   endtask

   task automatic model_reset();
      mdl_q.delete();
      exp_done_q.delete();
      m_ovr = 1'b0;
      m_fe  = 1'b0;
      m_pe  = 1'b0;
   endtask

   // Monitor: pop the predicted response whenever the DUT presents one
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && apb.PSEL && apb.PENABLE) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL apb_unexpected: access at addr 0x%0h with no prediction", apb.PADDR);
         end else begin
            e = exp_q.pop_front();
            if (e.is_read) check({e.name, " prdata"}, apb.PRDATA, e.data);
            check({e.name, " pslverr"}, 32'(apb.PSLVERR), 32'(e.err));
            check({e.name, " pready"}, 32'(apb.PREADY), 32'd1);
         end
      end
      if (rst_n && rx_done) begin
         n_checks++;
         if (exp_done_q.size() == 0) begin
            n_errors++;
            $display("FAIL rx_done_unexpected: got pulse expected none");
         end else begin
            void'(exp_done_q.pop_front());
         end
      end
   end

   initial begin
      rst_n       = 1'b0;
      rx_serial   = 1'b1;
      apb.PSEL    = 1'b0;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = 1'b0;
      apb.PADDR   = '0;
      apb.PWDATA  = '0;
      model_reset();
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      check("reset prdata",  apb.PRDATA, 32'd0);
      check("reset pslverr", 32'(apb.PSLVERR), 32'd0);
      check("reset pready",  32'(apb.PREADY), 32'd1);
      check_idle("reset");
      apb_read(4'h4, "reset status");

      // Single frame
      send_frame(8'hA5, 1'b1, 1'b0);
      check_idle("a5 frame");
      apb_read(4'h4, "a5 status");
      apb_read(4'h0, "a5 rxdata");
      apb_read(4'h4, "a5 status after pop");
      check_idle("a5 drained");

      // Overflow with back-to-back frames
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
      apb_read(4'h4, "ovf status");
      check_idle("ovf");
      for (int i = 0; i < 5; i++) apb_read(4'h0, "ovf rxdata");
      apb_write(4'h0, 32'hFF, "rxdata write");
      apb_read(4'h8, "reserved 8");
      apb_read(4'hC, "reserved c");
      apb_write(4'h4, 32'h04, "w1c overrun");
      apb_read(4'h4, "ovf status cleared");
      check_idle("ovf cleared");

      // Short low glitch on idle line
      rx_serial = 1'b0;
      repeat (5) tick();
      rx_serial = 1'b1;
      repeat (200) tick();
      apb_read(4'h4, "glitch status");
      check_idle("glitch");

      // Stop bit low
      send_frame(8'h3C, 1'b0, 1'b0);
      apb_read(4'h4, "frame_err status");
      check_idle("frame_err");
      apb_write(4'h4, 32'h08, "w1c frame_err");
      apb_read(4'h4, "frame_err cleared");

      // Reset part-way through the data bits of 0x55
      rx_serial = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 3; i++) begin
         rx_serial = (i % 2 == 0) ? 1'b1 : 1'b0;
         repeat (CPB) tick();
      end
      rst_n     = 1'b0;
      rx_serial = 1'b1;
      model_reset();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      check_idle("midframe reset");
      send_frame(8'h66, 1'b1, 1'b0);
      apb_read(4'h4, "after reset status");
      apb_read(4'h0, "after reset rxdata");
      apb_read(4'h4, "after reset empty");

      if (PAR_EN) begin
         send_frame(8'h07, 1'b1, 1'b1);
         apb_read(4'h4, "parity bad status");
         check_idle("parity bad");
         apb_write(4'h4, 32'h10, "w1c parity");
         send_frame(8'h07, 1'b1, 1'b0);
         apb_read(4'h0, "parity good rxdata");
      end

      // Randomised traffic
      for (int it = 0; it < 60; it++) begin
         int unsigned act;
         act = $urandom_range(0, 9);
         if (act <= 4) begin
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0,
                       PAR_EN && ($urandom_range(0, 3) == 0));
         end else if (act <= 7) begin
            apb_read(4'h0, "rand rxdata");
         end else if (act == 8) begin
            apb_read({2'($urandom_range(1, 3)), 2'b00}, "rand read");
         end else begin
            apb_write({2'($urandom_range(0, 3)), 2'b00}, $urandom, "rand write");
         end
         check_idle("rand");
      end

      // Drain and confirm every prediction was consumed
      while (mdl_q.size() > 0) apb_read(4'h0, "drain rxdata");
      apb_read(4'h4, "final status");
      repeat (4) tick();
      check("pending apb predictions", 32'(exp_q.size()), 32'd0);
      check("missing rx_done pulses", 32'(exp_done_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
